// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run-control sequencer: state and halt-cause
// encodings, the special instruction words it watches for, and the stop
// cause priority resolver.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_HALT_REQ   = 3'd1,
        CAUSE_BREAKPOINT = 3'd2,
        CAUSE_EBREAK     = 3'd3,
        CAUSE_ILLEGAL    = 3'd4,
        CAUSE_STEP_DONE  = 3'd5
    } halt_cause_t;

    localparam logic [31:0] EBREAK_WORD  = 32'h0010_0073;
    localparam logic [31:0] ILLEGAL_ZERO = 32'h0000_0000;
    localparam logic [31:0] ILLEGAL_ONES = 32'hFFFF_FFFF;

    // Picks the reported cause when several stop conditions coincide.
    function automatic halt_cause_t stop_cause(input logic illegal,
                                               input logic ebreak,
                                               input logic bp_hit,
                                               input logic halt_req);
        if (illegal)       return CAUSE_ILLEGAL;
        else if (ebreak)   return CAUSE_EBREAK;
        else if (bp_hit)   return CAUSE_BREAKPOINT;
        else if (halt_req) return CAUSE_HALT_REQ;
        else               return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle RV32 core. Decides every cycle
// whether the instruction at pc_i executes (PC advance and register
// write-back), supports start / halt / single-step / breakpoint, halts on
// EBREAK or illegal words without executing them, and counts retired
// instructions.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int          CNT_W  = 32,
    parameter logic [31:0] EBREAK = EBREAK_WORD
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             halt_req_i,
    input  logic             step_i,
    input  logic             bp_en_i,
    input  logic [31:0]      bp_addr_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    output logic             pc_en_o,
    output logic             wb_en_o,
    output logic [1:0]       state_o,
    output logic [2:0]       halt_cause_o,
    output logic [CNT_W-1:0] retired_o
);

    run_state_t       state_q, state_d;
    halt_cause_t      cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             bp_skip_q, bp_skip_d;

    logic             illegal;
    logic             ebreak;
    logic             bp_hit;
    logic             stop;
    halt_cause_t      stop_winner;
    logic             exec;

    // Decode stop conditions for the current instruction and decide, in the same cycle, whether it executes.
    always_comb begin
        illegal     = (instr_i == ILLEGAL_ZERO) || (instr_i == ILLEGAL_ONES);
        ebreak      = (instr_i == EBREAK);
        bp_hit      = bp_en_i && (pc_i == bp_addr_i) && !bp_skip_q;
        stop        = illegal || ebreak || bp_hit || halt_req_i;
        stop_winner = stop_cause(illegal, ebreak, bp_hit, halt_req_i);
        exec        = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !stop;
        pc_en_o     = exec;
        wb_en_o     = exec;
    end

    // Next state, halt cause, retired count and breakpoint-skip flag.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        bp_skip_d = bp_skip_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    cause_d   = CAUSE_NONE;
                    retired_d = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HALT;
                    cause_d = stop_winner;
                end else begin
                    retired_d = retired_q + CNT_W'(1);
                    bp_skip_d = 1'b0;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                if (stop) begin
                    cause_d = stop_winner;
                end else begin
                    cause_d   = CAUSE_STEP_DONE;
                    retired_d = retired_q + CNT_W'(1);
                    bp_skip_d = 1'b0;
                end
            end
            ST_HALT: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    cause_d   = CAUSE_NONE;
                    bp_skip_d = 1'b1;
                end else if (step_i) begin
                    state_d   = ST_STEP;
                    cause_d   = CAUSE_NONE;
                    bp_skip_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, cause, counter and skip flag registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
            bp_skip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            bp_skip_q <= bp_skip_d;
        end
    end

    assign state_o      = state_q;
    assign halt_cause_o = cause_q;
    assign retired_o    = retired_q;

endmodule
